spm_serial_mult: RTL and testbench



---
 rtl/spm_pkg.sv | 14 +
 rtl/spm_if.sv | 22 ++
 rtl/spm_csa_cell.sv | 42 ++++
 rtl/spm_serial_mult.sv | 100 ++++++++++
 tb/tb_spm_serial_mult.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier.
package spm_pkg;

    localparam int unsigned DEFAULT_SIZE = 8;
    localparam int unsigned PW           = 2 * DEFAULT_SIZE;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Counter width able to hold 0..2*size.
    function automatic int unsigned cnt_w(input int unsigned size);
        return $clog2(2 * size + 1);
    endfunction

endpackage

// File: rtl/spm_if.sv
// Operand/product handshake bundle for spm_serial_mult.
interface spm_if #(
    parameter int unsigned SIZE = spm_pkg::DEFAULT_SIZE
);
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     x;
    logic [SIZE-1:0]     y;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   p;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/spm_csa_cell.sv
// One bit slice of the serial-parallel array: registered upstream sum plus carry (sc) flop.
module spm_csa_cell #(
    parameter bit TCS = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x_bit,
    input  logic y_bit,
    input  logic s_in,
    output logic s_out
);
    logic pp;
    logic s_q;
    logic sc_q;
    logic sc_d;

    always_comb begin
        pp    = x_bit & y_bit;
        s_out = s_q ^ pp ^ sc_q;
        // TCS: sum = s_q - pp - sc_q, sc holds the pending borrow of the negative-weight bit.
        if (TCS) begin
            sc_d = s_q ? (pp & sc_q) : (pp | sc_q);
        end else begin
            sc_d = (pp & s_q) | (pp & sc_q) | (s_q & sc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= 1'b0;
            sc_q <= 1'b0;
        end else if (clr) begin
            s_q  <= 1'b0;
            sc_q <= 1'b0;
        end else if (en) begin
            s_q  <= s_in;
            sc_q <= sc_d;
        end
    end
endmodule

// File: rtl/spm_serial_mult.sv
// Serial-parallel signed multiplier: y streamed LSB-first through a CSA cell chain.
module spm_serial_mult import spm_pkg::*; #(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input logic  clk,
    input logic  rst,
    spm_if.slave bus
);
    localparam int unsigned PROD_W = 2 * SIZE;
    localparam int unsigned CW     = cnt_w(SIZE);
    localparam logic [CW-1:0] LAST = CW'(PROD_W - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [SIZE-1:0]     y_sh_q, y_sh_d;
    logic [PROD_W-1:0]   p_sh_q, p_sh_d;
    logic [PROD_W-1:0]   p_q, p_d;
    logic                clr;
    logic                en;
    logic [SIZE:0]       s_up;

    // Nothing lies above the top cell; its own borrow flop carries the sign.
    assign s_up[SIZE] = 1'b0;

    for (genvar i = 0; i < SIZE; i++) begin : g_cell
        spm_csa_cell #(
            .TCS (i == SIZE - 1)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (en),
            .x_bit (x_q[i]),
            .y_bit (y_sh_q[0]),
            .s_in  (s_up[i+1]),
            .s_out (s_up[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_sh_d  = y_sh_q;
        p_sh_d  = p_sh_q;
        p_d     = p_q;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d     = bus.x;
                    y_sh_d  = bus.y;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                en     = 1'b1;
                y_sh_d = {y_sh_q[SIZE-1], y_sh_q[SIZE-1:1]};
                p_sh_d = {s_up[0], p_sh_q[PROD_W-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    p_d     = p_sh_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_sh_q  <= '0;
            p_sh_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_sh_q  <= y_sh_d;
            p_sh_q  <= p_sh_d;
            p_q     <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.p         = p_q;
endmodule

// File: tb/tb_spm_serial_mult.sv
// Scoreboard bench for spm_serial_mult (SIZE=8): directed vectors plus back-to-back traffic.
module tb_spm_serial_mult;
    import spm_pkg::*;

    logic clk;
    logic rst;
    spm_if #(.SIZE(8)) bus ();

    spm_serial_mult #(.SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    bit          b2b = 1'b0;
    bit          have_rise = 1'b0;
    int          last_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event want none", name);
    endtask

    // Monitor: pops the scoreboard on every accepted product, checks latency and spacing.
    initial begin : monitor
        bit ov_prev;
        int a;
        ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                if (bus.out_valid && !ov_prev) begin
                    if (acc_q.size() == 0) fail("unexpected_valid");
                    else begin
                        a = acc_q.pop_front();
                        chk("latency", cyc - a, 17);
                    end
                    if (b2b && have_rise) chk("spacing", cyc - last_rise, 18);
                    last_rise = cyc;
                    have_rise = 1'b1;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) fail("unexpected_product");
                    else chk("product", bus.p, exp_q.pop_front());
                end
                ov_prev = bus.out_valid;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.x        = a;
        bus.y        = b;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            fail("accept_timeout");
        end else begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = ~a;
        bus.y        = ~b;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  dx[6]   = '{8'd3, 8'hFD, 8'd5, 8'h80, 8'd127, 8'd0};
    logic [7:0]  dy[6]   = '{8'd5, 8'd5, 8'hFD, 8'h80, 8'h80, 8'hFF};
    logic [15:0] dexp[6] = '{16'h000F, 16'hFFF1, 16'hFFF1, 16'h4000, 16'hC080, 16'h0000};

    initial begin : stim
        int         n;
        int         pa;
        logic [7:0] ra;
        logic [7:0] rb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_p", bus.p, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) send(dx[i], dy[i], dexp[i]);
        drain();

        // Backpressure: DONE must hold and ignore new operands.
        bus.out_ready = 1'b0;
        send(8'd2, 8'd3, 16'h0006);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) fail("done_timeout");
        bus.in_valid = 1'b1;
        bus.x        = 8'd11;
        bus.y        = 8'd11;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_p", bus.p, 16'h0006);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        send(8'd11, 8'd11, 16'h0079);
        drain();

        // Asynchronous reset in the middle of a RUN.
        send(8'd7, 8'd9, 16'h003F);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        #1;
        chk("midrun_in_ready", bus.in_ready, 1);
        chk("midrun_out_valid", bus.out_valid, 0);
        chk("midrun_p", bus.p, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd7, 8'd9, 16'h003F);
        drain();

        // Back-to-back random pairs against the arithmetic reference.
        b2b       = 1'b1;
        have_rise = 1'b0;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            pa = int'($signed(ra)) * int'($signed(rb));
            send(ra, rb, pa[15:0]);
        end
        drain();
        b2b = 1'b0;

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
